// File: rtl/vga_pkg.sv
// Shared constants, types and helpers for the VGA framebuffer scanout.
// Build option: define FB_PALETTE_EN to add a 256x24 palette stage (latency 4 instead of 3).
package vga_pkg;

    localparam int unsigned DEF_H_DISPLAY = 640;
    localparam int unsigned DEF_V_DISPLAY = 480;
    localparam int unsigned DEF_FB_WIDTH  = 320;
    localparam int unsigned DEF_FB_HEIGHT = 240;
    localparam int unsigned FB_DEPTH      = 76800;
    localparam int unsigned FB_AW         = 17;

`ifdef FB_PALETTE_EN
    localparam int unsigned PIX_LATENCY = 4;
`else
    localparam int unsigned PIX_LATENCY = 3;
`endif

    // Timing signals that travel alongside each pixel through the pipeline.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } sync_t;

    // Syncs idle high and data enable low while in reset.
    localparam sync_t SYNC_RST = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0};

    // 3-3-2 to 8-8-8 expansion by bit replication so full-scale codes reach 0xFF.
    function automatic logic [23:0] expand_332(input logic [7:0] d);
        return {d[7:5], d[7:5], d[7:6],
                d[4:2], d[4:2], d[4:3],
                {4{d[1:0]}}};
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Single-port framebuffer RAM: synchronous read with one cycle latency, no reset so it maps
// onto block RAM. Contents are undefined at power-up and untouched by reset.
module fb_ram
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH = FB_DEPTH,
    parameter int unsigned AW    = FB_AW,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // One shared port: write when enabled, always register the old word at addr.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/vga_fb_scanout.sv
// 2x-scaled framebuffer scanout: turns sync-generator position into RGB with matching delayed
// syncs. Host writes share the single RAM port and are only accepted during blanking.
// Build option: FB_PALETTE_EN inserts a 256x24 palette lookup stage (latency 4, palette ports).
module vga_fb_scanout
    import vga_pkg::*;
#(
    parameter int unsigned FB_WIDTH  = DEF_FB_WIDTH,
    parameter int unsigned FB_HEIGHT = DEF_FB_HEIGHT,
    parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
    parameter int unsigned V_DISPLAY = DEF_V_DISPLAY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      hpos,
    input  logic [10:0]      vpos,
    input  logic             display_on,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [FB_AW-1:0] wr_addr,
    input  logic [7:0]       wr_data,
`ifdef FB_PALETTE_EN
    input  logic             pal_wr_en,
    input  logic [7:0]       pal_addr,
    input  logic [23:0]      pal_data,
`endif
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue
);

    localparam int unsigned DEPTH = FB_WIDTH * FB_HEIGHT;

    logic [FB_AW-1:0] line_base_q, line_base_d;
    logic [FB_AW-1:0] pix_addr;
    logic [FB_AW-1:0] addr_q;
    logic             we_q;
    logic [7:0]       wdata_q;
    logic             wr_fire;
    logic [7:0]       rd_data;

    sync_t                   sync_in;
    sync_t [PIX_LATENCY-1:0] sync_q;

    logic [23:0] pix_rgb;
    logic        pix_de;
    logic [23:0] rgb_q;

    assign wr_ready = ~display_on & ~reset;
    assign wr_fire  = wr_valid & wr_ready;
    assign pix_addr = line_base_q + FB_AW'(hpos[10:1]);
    assign sync_in  = {hsync_in, vsync_in, display_on};

    // Advance the row base once per line at the end of the visible area; only odd lines step
    // because each framebuffer row is shown twice. Vertical blanking lines leave it alone.
    always_comb begin
        line_base_d = line_base_q;
        if (hpos == 11'(H_DISPLAY)) begin
            if (vpos == 11'(V_DISPLAY - 1)) begin
                line_base_d = '0;
            end else if (vpos[0] && (vpos < 11'(V_DISPLAY))) begin
                line_base_d = line_base_q + FB_AW'(FB_WIDTH);
            end
        end
    end

    // Stage 1: register the RAM address. A host write rides this stage in place of the pixel
    // read, so the RAM port is only taken away from a blanking slot. Out-of-range writes are
    // accepted but dropped here.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_base_q <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
        end else begin
            line_base_q <= line_base_d;
            addr_q      <= wr_fire ? wr_addr : pix_addr;
            we_q        <= wr_fire && (wr_addr < FB_AW'(DEPTH));
            wdata_q     <= wr_data;
        end
    end

    // Stage 2: RAM data (its output register is not reset; the data enable masks it).
    fb_ram #(
        .DEPTH (DEPTH),
        .AW    (FB_AW),
        .DW    (8)
    ) u_fb_ram (
        .clk   (clk),
        .we    (we_q),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (rd_data)
    );

    // Delay the syncs and data enable to line up with the colour output.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {PIX_LATENCY{SYNC_RST}};
        end else begin
            sync_q <= {sync_q[PIX_LATENCY-2:0], sync_in};
        end
    end

    // Data enable for the pixel whose colour enters the output register this cycle.
    assign pix_de = sync_q[PIX_LATENCY-2].de;

`ifdef FB_PALETTE_EN
    logic [23:0] pal_mem [256];
    logic [23:0] pal_q;

    // Palette writes in any cycle; extra stage looks up the RAM word. Reset blacks the table.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) begin
                pal_mem[i] <= '0;
            end
            pal_q <= '0;
        end else begin
            if (pal_wr_en) begin
                pal_mem[pal_addr] <= pal_data;
            end
            pal_q <= pal_mem[rd_data];
        end
    end

    assign pix_rgb = pal_q;
`else
    assign pix_rgb = expand_332(rd_data);
`endif

    // Output register: colour forced to black outside the active area.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= pix_de ? pix_rgb : 24'h0;
        end
    end

    assign {red, green, blue} = rgb_q;
    assign hsync = sync_q[PIX_LATENCY-1].hsync;
    assign vsync = sync_q[PIX_LATENCY-1].vsync;
    assign de    = sync_q[PIX_LATENCY-1].de;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Directed bench for vga_fb_scanout: drives position/sync/write inputs one cycle at a time and
// checks outputs against a scoreboard of expected values from a behavioural framebuffer model.
`timescale 1ns/1ps
module tb_vga_fb_scanout;

    localparam int DEPTH = 76800;
`ifdef FB_PALETTE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hpos, vpos;
    logic        display_on, hsync_in, vsync_in;
    logic        wr_valid, wr_ready;
    logic [16:0] wr_addr;
    logic [7:0]  wr_data;
    logic        hsync, vsync, de;
    logic [7:0]  red, green, blue;
`ifdef FB_PALETTE_EN
    logic        pal_wr_en = 1'b0;
    logic [7:0]  pal_addr  = 8'h0;
    logic [23:0] pal_data  = 24'h0;
`endif

    vga_fb_scanout dut (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
`ifdef FB_PALETTE_EN
        .pal_wr_en  (pal_wr_en),
        .pal_addr   (pal_addr),
        .pal_data   (pal_data),
`endif
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .red        (red),
        .green      (green),
        .blue       (blue)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
        bit          chk;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mdl[int];
    int         total = 0;
    int         bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference colour for a stored byte; palette builds never load the palette (all black).
    function automatic logic [23:0] color(input logic [7:0] d);
        logic [7:0] r3, g3, b2, r, g, b;
        r3 = {5'b0, d[7:5]};
        g3 = {5'b0, d[4:2]};
        b2 = {6'b0, d[1:0]};
        r  = (r3 << 5) | (r3 << 2) | (r3 >> 1);
        g  = (g3 << 5) | (g3 << 2) | (g3 >> 1);
        b  = b2 * 8'h55;
`ifdef FB_PALETTE_EN
        return {r, g, b} & 24'h0;
`else
        return {r, g, b};
`endif
    endfunction

    task automatic pop_check();
        exp_t e;
        e = sb.pop_front();
        check("hsync", hsync, e.hs);
        check("vsync", vsync, e.vs);
        check("de", de, e.de);
        if (e.chk) check("rgb", {red, green, blue}, e.rgb);
    endtask

    // One clock cycle of stimulus; expected output is queued and compared LAT cycles later.
    task automatic step(input bit rst, input int h, input int v, input bit don, input bit hs,
                        input bit vs, input bit wv = 1'b0, input int wa = 0,
                        input logic [7:0] wd = 8'h0);
        exp_t e;
        int   word;
        reset      = rst;
        hpos       = 11'(h);
        vpos       = 11'(v);
        display_on = don;
        hsync_in   = hs;
        vsync_in   = vs;
        wr_valid   = wv;
        wr_addr    = 17'(wa);
        wr_data    = wd;
        #1;
        check("wr_ready", wr_ready, !don && !rst);
        if (wv && !don && !rst && wa < DEPTH) mdl[wa] = wd;
        e.hs  = hs;
        e.vs  = vs;
        e.de  = don;
        e.rgb = 24'h0;
        e.chk = 1'b1;
        if (don) begin
            word = (v / 2) * 320 + h / 2;
            if (mdl.exists(word)) e.rgb = color(mdl[word]);
            else e.chk = 1'b0;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            check("rst_de", de, 1'b0);
            check("rst_hsync", hsync, 1'b1);
            check("rst_vsync", vsync, 1'b1);
            check("rst_rgb", {red, green, blue}, 24'h0);
            sb.delete();
            for (int i = 0; i < LAT - 1; i++) begin
                exp_t r;
                r.hs = 1'b1; r.vs = 1'b1; r.de = 1'b0; r.rgb = 24'h0; r.chk = 1'b1;
                sb.push_back(r);
            end
        end else begin
            sb.push_back(e);
            if (sb.size() == LAT) pop_check();
        end
    endtask

    initial begin
        // Reset, with a write attempt that must be refused.
        step(1, 0, 0, 0, 1, 1, 1, 5, 8'hAA);
        step(1, 0, 0, 0, 1, 1);

        // Blanking writes, including one past the end of the framebuffer.
        step(0, 700, 0, 0, 1, 1, 1, 0, 8'hE0);
        step(0, 700, 0, 0, 1, 1, 1, 320, 8'h1C);
        step(0, 700, 0, 0, 1, 1, 1, 1, 8'h5A);
        step(0, 700, 0, 0, 1, 1, 1, 3, 8'h77);
        step(0, 700, 0, 0, 1, 1, 1, 640, 8'h03);
        step(0, 700, 0, 0, 1, 1, 1, 11264, 8'h33);
        step(0, 700, 0, 0, 1, 1, 1, 76480, 8'h69);
        step(0, 700, 0, 0, 1, 1, 1, 76799, 8'hC3);
        step(0, 700, 0, 0, 1, 1, 1, 76800, 8'hFF);

        // Write held across visible pixels reading the same word: must not land until blanking.
        step(0, 6, 0, 1, 1, 1, 1, 3, 8'h11);
        step(0, 7, 0, 1, 1, 1, 1, 3, 8'h11);
        step(0, 700, 0, 0, 1, 1, 1, 3, 8'h11);
        step(0, 700, 0, 0, 1, 1);

        // First frame: detailed top rows, hsync pulse on line 0, spot checks deeper down.
        for (int v = 0; v < 480; v++) begin
            if (v < 5) begin
                for (int h = 0; h < 8; h++) step(0, h, v, 1, 1, 1);
            end else if (v == 70) begin
                step(0, 128, v, 1, 1, 1);
                step(0, 129, v, 1, 1, 1);
            end else if (v == 478) begin
                step(0, 0, v, 1, 1, 1);
                step(0, 1, v, 1, 1, 1);
                step(0, 638, v, 1, 1, 1);
                step(0, 639, v, 1, 1, 1);
            end else begin
                step(0, 0, v, 1, 1, 1);
            end
            if (v == 0) begin
                for (int h = 640; h < 800; h++) step(0, h, v, 0, !(h >= 656 && h <= 751), 1);
            end else begin
                step(0, 640, v, 0, 1, 1);
            end
        end

        // Vertical blanking with a vsync pulse.
        for (int v = 480; v < 525; v++) step(0, 640, v, 0, 1, !(v == 490 || v == 491));

        // Second frame: line base restarted; then reset mid-line on a non-zero line base.
        for (int v = 0; v < 5; v++) begin
            for (int h = 0; h < 4; h++) step(0, h, v, 1, 1, 1);
            step(0, 640, v, 0, 1, 1);
        end
        step(0, 298, 5, 1, 0, 0);
        step(0, 299, 5, 1, 0, 0);
        step(1, 300, 5, 1, 0, 0);
        step(0, 0, 0, 1, 1, 1);
        step(0, 1, 0, 1, 1, 1);
        step(0, 2, 0, 1, 1, 1);
        step(0, 3, 0, 1, 1, 1);

        // Drain the scoreboard.
        for (int i = 0; i < LAT - 1; i++) step(0, 700, 0, 0, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
